// File: rtl/fp_sqrt_rem.sv
// rtl/fp_sqrt_rem.sv - multi-bit-per-cycle restoring fixed-point square root with remainder.
// Optional round-to-nearest on the root output: define FP_SQRT_ROUND_EN.
module fp_sqrt_rem #(
  parameter int WIDTH          = 32,
  parameter int INT_WIDTH      = 16,
  parameter int FRAC_WIDTH     = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH+1:0] rem,
  output logic             done,
  output logic             busy
);

  localparam int RW    = WIDTH + FRAC_WIDTH;
  localparam int ITER  = RW / 2;
  localparam int STEPS = ITER / BITS_PER_CYCLE;
  localparam int CW    = (STEPS < 2) ? 1 : $clog2(STEPS + 1);

  if ((RW % 2) != 0 || (ITER % BITS_PER_CYCLE) != 0 || (INT_WIDTH + FRAC_WIDTH) != WIDTH)
  begin : g_bad_cfg
    $error("fp_sqrt_rem: invalid parameter combination");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    rad_q, rad_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH+1:0] rem_q, rem_d;
  logic             done_q, done_d;

  always_comb begin
    logic [RW-1:0]    r;
    logic [WIDTH-1:0] qv;
    logic [WIDTH+1:0] av;
    logic [WIDTH+3:0] sh;
    logic [WIDTH+3:0] trial;

    state_d = state_q;
    rad_d   = rad_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rem_d   = rem_q;
    done_d  = 1'b0;

    // Chain of restoring steps; two extra bits on the trial keep the sign exact.
    r  = rad_q;
    qv = q_q;
    av = acc_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      sh    = {av, r[RW-1 -: 2]};
      trial = sh - {2'b00, qv, 2'b01};
      r     = r << 2;
      if (!trial[WIDTH+3]) begin
        av = (WIDTH+2)'(trial);
        qv = (qv << 1) | WIDTH'(1);
      end else begin
        av = (WIDTH+2)'(sh);
        qv = qv << 1;
      end
    end

    case (state_q)
      IDLE: begin
        if (go) begin
          rad_d   = RW'(in) << FRAC_WIDTH;
          q_d     = '0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rad_d = r;
        q_d   = qv;
        acc_d = av;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(STEPS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rem_d   = av;
`ifdef FP_SQRT_ROUND_EN
          if (av > {2'b00, qv}) out_d = (&qv) ? qv : qv + 1'b1;
          else                  out_d = qv;
`else
          out_d = qv;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rad_q   <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign rem  = rem_q;
  assign done = done_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_fp_sqrt_rem.sv
// tb/tb_fp_sqrt_rem.sv - randomized self-checking bench for fp_sqrt_rem (two configurations).
module tb_fp_sqrt_rem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go0 = 1'b0, go1 = 1'b0;
  logic [31:0] in0 = '0, in1 = '0;
  logic [31:0] out0, out1;
  logic [33:0] rem0, rem1;
  logic        done0, done1, busy0, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Integer format, one root bit per clock.
  fp_sqrt_rem #(.WIDTH(32), .INT_WIDTH(32), .FRAC_WIDTH(0), .BITS_PER_CYCLE(1)) dut0 (
    .clk(clk), .reset(reset), .go(go0), .in(in0),
    .out(out0), .rem(rem0), .done(done0), .busy(busy0)
  );

  // Q16.16, four root bits per clock.
  fp_sqrt_rem #(.WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16), .BITS_PER_CYCLE(4)) dut1 (
    .clk(clk), .reset(reset), .go(go1), .in(in1),
    .out(out1), .rem(rem1), .done(done1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Largest q with q*q <= in*2^frac, found by squaring candidates.
  task automatic model(input int frac, input logic [31:0] v,
                       output longint unsigned q, output longint unsigned r);
    longint unsigned rad, t;
    rad = longint'(v) << frac;
    q = 0;
    for (int b = 31; b >= 0; b--) begin
      t = q | (64'd1 << b);
      if (t * t <= rad) q = t;
    end
    r = rad - q * q;
  endtask

  function automatic longint unsigned exp_out(input longint unsigned q, input longint unsigned r);
`ifdef FP_SQRT_ROUND_EN
    if (r > q) return (q == 64'hFFFF_FFFF) ? q : q + 1;
`endif
    return r - r + q;
  endfunction

  function automatic logic cur_done(input int sel);
    return sel != 0 ? done1 : done0;
  endfunction
  function automatic logic cur_busy(input int sel);
    return sel != 0 ? busy1 : busy0;
  endfunction
  function automatic logic [63:0] cur_out(input int sel);
    return sel != 0 ? 64'(out1) : 64'(out0);
  endfunction
  function automatic logic [63:0] cur_rem(input int sel);
    return sel != 0 ? 64'(rem1) : 64'(rem0);
  endfunction

  task automatic run_op(input int sel, input logic [31:0] val);
    longint unsigned eq, er;
    int cyc, steps;
    steps = (sel != 0) ? 6 : 16;
    model((sel != 0) ? 16 : 0, val, eq, er);
    @(negedge clk);
    if (sel != 0) begin go1 = 1'b1; in1 = val; end
    else          begin go0 = 1'b1; in0 = val; end
    @(negedge clk);
    go0 = 1'b0;
    go1 = 1'b0;
    check("busy_after_accept", 64'(cur_busy(sel)), 64'd1);
    check("no_early_done", 64'(cur_done(sel)), 64'd0);
    cyc = 0;
    while (!cur_done(sel) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 64'(cyc), 64'(steps));
    check("out", cur_out(sel), exp_out(eq, er));
    check("rem", cur_rem(sel), er);
    check("busy_at_done", 64'(cur_busy(sel)), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(cur_done(sel)), 64'd0);
    check("out_held", cur_out(sel), exp_out(eq, er));
  endtask

  initial begin
    int t[$];
    int cnt;
    #1;
    check("rst_out0", 64'(out0), 64'd0);
    check("rst_rem0", 64'(rem0), 64'd0);
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_done1", 64'(done1), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed corner values.
    run_op(0, 32'd16);
    run_op(0, 32'hFFFF_FFFF);
    run_op(0, 32'd0);
    run_op(0, 32'd15);
    run_op(0, 32'd1);
    run_op(1, 32'h0002_0000);
    run_op(1, 32'h0000_0000);
    run_op(1, 32'hFFFF_FFFF);
    run_op(1, 32'h0001_0000);

    for (int i = 0; i < 12; i++) begin
      run_op(0, (i % 2 != 0) ? $urandom : $urandom_range(0, 1000));
      run_op(1, (i % 2 != 0) ? $urandom : $urandom_range(0, 1000));
    end

    // go held high: restart every STEPS+1 cycles.
    @(negedge clk);
    go0 = 1'b1;
    in0 = 32'd144;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done0) begin
        t.push_back(c);
        check("hold_out", 64'(out0), 64'd12);
      end
    end
    go0 = 1'b0;
    check("hold_count_ok", 64'(t.size() >= 3), 64'd1);
    for (int i = 1; i < t.size(); i++) check("hold_period", 64'(t[i] - t[i-1]), 64'd17);
    cnt = 0;
    while ((busy0 || done0) && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("hold_drain", 64'(busy0), 64'd0);

    // go during RUN is ignored and in is not re-sampled.
    @(negedge clk);
    go0 = 1'b1;
    in0 = 32'd81;
    @(negedge clk);
    go0 = 1'b0;
    repeat (4) @(negedge clk);
    go0 = 1'b1;
    in0 = 32'd100;
    @(negedge clk);
    go0 = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done0) begin
        cnt++;
        check("busy_go_out", 64'(out0), 64'd9);
        check("busy_go_rem", 64'(rem0), 64'd0);
      end
    end
    check("busy_go_done_count", 64'(cnt), 64'd1);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    go0 = 1'b1;
    in0 = 32'd200;
    @(negedge clk);
    go0 = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_out0", 64'(out0), 64'd0);
    check("arst_rem0", 64'(rem0), 64'd0);
    check("arst_busy0", 64'(busy0), 64'd0);
    check("arst_out1", 64'(out1), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done0) cnt++;
    end
    check("arst_no_done", 64'(cnt), 64'd0);
    run_op(0, 32'd49);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_sqrt_rem.md
# fp_sqrt_rem

Parametrised multi-bit-per-cycle fixed-point square root with remainder output, busy flag and optional round-to-nearest. It succeeds the single-bit fp_sqrt and adds four things: a configurable number of root bits resolved per clock, an exact remainder output, an asynchronous reset, and explicit idle/busy status. It sits behind the same go/done protocol, so Calyx invoke groups drive it unchanged.

## Interface
- WIDTH, 32, operand and result width
- INT_WIDTH, 16, integer bits of the fixed-point format
- FRAC_WIDTH, 16, fractional bits; WIDTH+FRAC_WIDTH must be even
- BITS_PER_CYCLE, 1, root bits resolved per clock; must divide ITERATIONS=(WIDTH+FRAC_WIDTH)/2
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- go  input  1  start request, sampled only while idle
- in  input  WIDTH  radicand, captured on the accepting edge
- out  output  WIDTH  root in the same fixed-point format, held until next completion
- rem  output  WIDTH+2  remainder (in·2^FRAC_WIDTH − q²), zero-extended
- done  output  1  one-cycle pulse, out/rem valid and newly updated
- busy  output  1  high while an operation is in flight

## Operation
- STEPS = ITERATIONS/BITS_PER_CYCLE. States: IDLE, RUN.
- IDLE: busy=0. go=1 at an edge captures in, clears quotient/acc, zeroes the step counter and moves to RUN.
- RUN: each edge performs BITS_PER_CYCLE chained restoring-sqrt steps combinationally.
  - Each step: acc = {acc, next 2 radicand bits}; trial = acc − {q, 2'b01}.
  - If trial ≥ 0: acc = trial and append 1 to q. Otherwise append 0 to q.
  - Working radicand is in·2^FRAC_WIDTH shifted out 2 bits per step. acc is WIDTH+2 bits wide; trial sign is its MSB.
- On the edge completing step STEPS: out←q (or rounded q), rem←acc, done←1, busy←0, state→IDLE.
- go while in RUN is ignored; in is not re-sampled.
- go high on the completion edge is ignored (state is still RUN at that edge). go sampled on the following edge starts a new operation.
- go held permanently high restarts every STEPS+1 cycles.
- out and rem keep their last values until the next completion. done is 0 on all non-completion cycles.
- Reset (asynchronous, any time, including mid-RUN) clears all state:
  - out=0, rem=0, done=0, busy=0, state=IDLE.
  - The aborted operation produces no done.
  - The first edge after reset deasserts may accept go.

## Timing
- Accept edge k (go=1, IDLE) → busy=1 from after edge k.
- Iteration edges k+1 … k+STEPS. done=1, busy=0 and new out/rem visible after edge k+STEPS.
- Latency STEPS cycles go-to-done; throughput one result per STEPS+1 cycles.
- Combinational depth grows linearly with BITS_PER_CYCLE (chained subtractors).
- No combinational path from go or in to any output.

## Configuration
- FP_SQRT_ROUND_EN defined:
  - On completion, out = q+1 when rem > q, else q (round to nearest; ties cannot occur). Saturates at all-ones if q+1 overflows WIDTH.
  - rem still reports the truncated remainder, relative to unrounded q.
- FP_SQRT_ROUND_EN undefined: out = q (truncation), identical to fp_sqrt results.

## Test plan
- WIDTH=32, FRAC_WIDTH=0, BITS_PER_CYCLE=1: in=16 at edge k → done at edge k+16, out=4, rem=0, busy low same edge.
- Same config, in=0xFFFFFFFF → out=65535, rem=131070. in=0 → out=0, rem=0.
- WIDTH=32, FRAC_WIDTH=16, BITS_PER_CYCLE=4: in=0x00020000 (2.0) → done exactly 6 cycles after accept, out=0x00016A09; with FP_SQRT_ROUND_EN out=0x00016A0A.
- FRAC_WIDTH=0, in=15 → out=3, rem=6; with FP_SQRT_ROUND_EN out=4.
- go pulses with in=100 while busy during a run on in=81 → result out=9, no second done. go held high → done every STEPS+1 cycles.
- reset asserted mid-RUN between edges → outputs 0 immediately, no done. Fresh go=1, in=49 after release → out=7 after STEPS.
